usb_rx_fsm: RTL and testbench

USB receive packet decoder. Sits between the UTMI RX interface and the protocol layer, mirroring the transmit path. It validates the PID/complement byte and checks CRC5 on token packets and CRC16 on data packets. It extracts token fields and forwards data payload as a byte stream with the two CRC bytes stripped, then reports one status pulse per packet.

---
 rtl/usb_rx_fsm.sv | 229 ++++++++++++++++++++++
 tb/tb_usb_rx_fsm.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_fsm.sv
// USB receive packet decoder: PID check, CRC5/CRC16 verification, token field
// extraction and payload forwarding with the two trailing CRC bytes held back.
module usb_rx_fsm #(
    parameter int MAX_PAYLOAD = 1024,
    parameter int CNT_W       = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       utmi_rx_data,
    input  logic             utmi_rx_valid,
    input  logic             utmi_rx_active,
    input  logic             utmi_rx_error,
    output logic [3:0]       rx_pid,
    output logic             rx_pid_valid,
    output logic [6:0]       rx_token_addr,
    output logic [3:0]       rx_token_endp,
    output logic [10:0]      rx_frame_num,
    output logic [7:0]       rx_packet_data,
    output logic             rx_packet_valid,
    output logic             rx_packet_sop,
    output logic             rx_packet_eop,
    output logic             rx_done,
    output logic [CNT_W-1:0] rx_byte_count,
    output logic             rx_crc_err,
    output logic             rx_pid_err,
    output logic             rx_len_err
);
    typedef enum logic [2:0] {IDLE, PID, TOKEN, DATA, HANDSHAKE, DISCARD, DONE} state_t;

    localparam logic [CNT_W:0]   N_ONE = (CNT_W+1)'(1);
    localparam logic [CNT_W:0]   N_TWO = (CNT_W+1)'(2);
    localparam logic [CNT_W:0]   N_LIM = (CNT_W+1)'(MAX_PAYLOAD + 2);
    localparam logic [CNT_W:0]   N_SAT = (CNT_W+1)'(MAX_PAYLOAD + 3);
    localparam logic [CNT_W-1:0] O_ONE = CNT_W'(1);

    state_t           state, state_nxt;
    logic             act_d, rise, pid_ok;
    logic [7:0]       hb [3];
    logic [1:0]       hb_cnt;
    logic [CNT_W:0]   n_in;
    logic [CNT_W-1:0] n_out;
    logic             sop_pend, fwd_en;
    logic [7:0]       tok_b1;
    logic             len_e, pid_e, crc_e;
    logic [4:0]       crc5, crc5_nxt;
    logic [15:0]      crc16, crc16_nxt;

    assign rise   = utmi_rx_active & ~act_d;
    assign pid_ok = (utmi_rx_data[7:4] == ~utmi_rx_data[3:0]);

    function automatic state_t pid_branch(input logic [3:0] p);
        pid_branch = DISCARD;
        case (p[1:0])
            2'b01:   pid_branch = TOKEN;
            2'b11:   pid_branch = DATA;
            2'b10:   pid_branch = HANDSHAKE;
            default: if (p == 4'h4) pid_branch = TOKEN;
        endcase
    endfunction

    always_comb begin
        crc5_nxt  = crc5;
        crc16_nxt = crc16;
        for (int i = 0; i < 8; i++) begin
            crc5_nxt  = {crc5_nxt[3:0], 1'b0} ^ ((utmi_rx_data[i] ^ crc5_nxt[4]) ? 5'h05 : 5'h00);
            crc16_nxt = {crc16_nxt[14:0], 1'b0} ^ ((utmi_rx_data[i] ^ crc16_nxt[15]) ? 16'h8005 : 16'h0000);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (rise) state_nxt = PID;
            DONE: state_nxt = rise ? PID : IDLE;
            default: begin
                if (!utmi_rx_active)    state_nxt = DONE;
                else if (utmi_rx_error) state_nxt = DISCARD;
                else if (utmi_rx_valid) begin
                    case (state)
                        PID:       state_nxt = pid_ok ? pid_branch(utmi_rx_data[3:0]) : DISCARD;
                        TOKEN:     if (n_in == N_TWO) state_nxt = DISCARD;
                        HANDSHAKE: state_nxt = DISCARD;
                        default:   ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act_d           <= 1'b1;  // a packet already in flight at reset release is not a rise
            rx_pid          <= '0;
            rx_pid_valid    <= 1'b0;
            rx_token_addr   <= '0;
            rx_token_endp   <= '0;
            rx_frame_num    <= '0;
            rx_packet_data  <= '0;
            rx_packet_valid <= 1'b0;
            rx_packet_sop   <= 1'b0;
            rx_packet_eop   <= 1'b0;
            rx_done         <= 1'b0;
            rx_byte_count   <= '0;
            rx_crc_err      <= 1'b0;
            rx_pid_err      <= 1'b0;
            rx_len_err      <= 1'b0;
            hb[0] <= '0; hb[1] <= '0; hb[2] <= '0;
            hb_cnt   <= '0;
            n_in     <= '0;
            n_out    <= '0;
            sop_pend <= 1'b0;
            fwd_en   <= 1'b0;
            tok_b1   <= '0;
            len_e    <= 1'b0;
            pid_e    <= 1'b0;
            crc_e    <= 1'b0;
            crc5     <= 5'h1F;
            crc16    <= 16'hFFFF;
        end else begin
            act_d           <= utmi_rx_active;
            rx_pid_valid    <= 1'b0;
            rx_packet_valid <= 1'b0;
            rx_packet_sop   <= 1'b0;
            rx_packet_eop   <= 1'b0;
            rx_done         <= 1'b0;
            rx_crc_err      <= 1'b0;
            rx_pid_err      <= 1'b0;
            rx_len_err      <= 1'b0;
            case (state)
                IDLE: ;
                DONE: begin
                    rx_done       <= 1'b1;
                    rx_byte_count <= n_out;
                    rx_crc_err    <= crc_e;
                    rx_pid_err    <= pid_e;
                    rx_len_err    <= len_e;
                end
                default: begin
                    if (!utmi_rx_active) begin
                        case (state)
                            PID:   pid_e <= 1'b1;
                            TOKEN: if (n_in != N_TWO) len_e <= 1'b1;
                                   else crc_e <= (crc5 != 5'b01100);
                            DATA: begin
                                if (n_in < N_TWO) len_e <= 1'b1;
                                else if (!len_e) begin
                                    crc_e <= (crc16 != 16'h800D);
                                    if (hb_cnt == 2'd3) begin
                                        rx_packet_data  <= hb[0];
                                        rx_packet_valid <= 1'b1;
                                        rx_packet_sop   <= sop_pend;
                                        rx_packet_eop   <= 1'b1;
                                        n_out           <= n_out + O_ONE;
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end else if (utmi_rx_error) begin
                        len_e  <= 1'b1;
                        fwd_en <= 1'b0;
                    end else if (utmi_rx_valid) begin
                        case (state)
                            PID: begin
                                if (pid_ok) begin
                                    rx_pid       <= utmi_rx_data[3:0];
                                    rx_pid_valid <= 1'b1;
                                end else pid_e <= 1'b1;
                            end
                            TOKEN: begin
                                crc5 <= crc5_nxt;
                                n_in <= n_in + N_ONE;
                                if (n_in == '0) tok_b1 <= utmi_rx_data;
                                if (n_in == N_ONE) begin
                                    rx_token_addr <= tok_b1[6:0];
                                    rx_token_endp <= {utmi_rx_data[2:0], tok_b1[7]};
                                    rx_frame_num  <= {utmi_rx_data[2:0], tok_b1};
                                end
                                if (n_in == N_TWO) len_e <= 1'b1;
                            end
                            DATA: begin
                                crc16 <= crc16_nxt;
                                if (n_in < N_SAT) n_in <= n_in + N_ONE;
                                if (n_in >= N_LIM) begin
                                    len_e  <= 1'b1;
                                    fwd_en <= 1'b0;
                                end else if (fwd_en) begin
                                    // three bytes stay buffered so the CRC pair never leaks out
                                    if (hb_cnt == 2'd3) begin
                                        rx_packet_data  <= hb[0];
                                        rx_packet_valid <= 1'b1;
                                        rx_packet_sop   <= sop_pend;
                                        sop_pend        <= 1'b0;
                                        n_out           <= n_out + O_ONE;
                                        hb[0] <= hb[1];
                                        hb[1] <= hb[2];
                                        hb[2] <= utmi_rx_data;
                                    end else begin
                                        hb[hb_cnt] <= utmi_rx_data;
                                        hb_cnt     <= hb_cnt + 2'd1;
                                    end
                                end
                            end
                            HANDSHAKE: len_e <= 1'b1;
                            default: ;
                        endcase
                    end
                end
            endcase
            if (state != PID && state_nxt == PID) begin
                hb_cnt   <= '0;
                n_in     <= '0;
                n_out    <= '0;
                sop_pend <= 1'b1;
                fwd_en   <= 1'b1;
                len_e    <= 1'b0;
                pid_e    <= 1'b0;
                crc_e    <= 1'b0;
                crc5     <= 5'h1F;
                crc16    <= 16'hFFFF;
            end
        end
    end
endmodule

// File: tb/tb_usb_rx_fsm.sv
// Scoreboard bench for usb_rx_fsm: packets are built and predicted from the
// USB framing rules, then PID, payload and status outputs are matched in order.
module tb_usb_rx_fsm;
    localparam int MAX   = 1024;
    localparam int CNT_W = 11;

    typedef struct packed {
        logic pe, ce, le, tok, eopc;
        logic [6:0]  addr;
        logic [3:0]  endp;
        logic [10:0] frm;
        logic [10:0] cnt;
    } st_t;

    logic clk = 1'b0, rst, act, vld, rxe;
    logic [7:0] d;
    logic [3:0] rx_pid;
    logic rx_pid_valid, rx_packet_valid, rx_packet_sop, rx_packet_eop, rx_done;
    logic rx_crc_err, rx_pid_err, rx_len_err;
    logic [6:0] rx_token_addr;
    logic [3:0] rx_token_endp;
    logic [10:0] rx_frame_num;
    logic [7:0] rx_packet_data;
    logic [CNT_W-1:0] rx_byte_count;

    int n_vec = 0, n_err = 0;
    logic [7:0] pkt [$];
    logic [3:0] pid_q [$];
    logic [9:0] byte_q [$];
    st_t st_q [$];
    logic eop_d = 1'b0;
    logic [7:0] dpids [4] = '{8'hC3, 8'h4B, 8'h87, 8'h0F};
    logic [7:0] tpids [4] = '{8'h69, 8'hE1, 8'hA5, 8'hB4};

    always #5 clk = ~clk;

    usb_rx_fsm #(.MAX_PAYLOAD(MAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .utmi_rx_data(d), .utmi_rx_valid(vld),
        .utmi_rx_active(act), .utmi_rx_error(rxe), .rx_pid(rx_pid),
        .rx_pid_valid(rx_pid_valid), .rx_token_addr(rx_token_addr),
        .rx_token_endp(rx_token_endp), .rx_frame_num(rx_frame_num),
        .rx_packet_data(rx_packet_data), .rx_packet_valid(rx_packet_valid),
        .rx_packet_sop(rx_packet_sop), .rx_packet_eop(rx_packet_eop),
        .rx_done(rx_done), .rx_byte_count(rx_byte_count), .rx_crc_err(rx_crc_err),
        .rx_pid_err(rx_pid_err), .rx_len_err(rx_len_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] x);
        for (int i = 0; i < 8; i++) rev8[i] = x[7-i];
    endfunction

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
        for (int i = 0; i < 8; i++) c = {c[14:0], 1'b0} ^ ((b[i] ^ c[15]) ? 16'h8005 : 16'h0);
        return c;
    endfunction

    function automatic logic [4:0] crc5_bits(input logic [4:0] c, input logic [15:0] v, input int nb);
        for (int i = 0; i < nb; i++) c = {c[3:0], 1'b0} ^ ((v[i] ^ c[4]) ? 5'h05 : 5'h0);
        return c;
    endfunction

    task automatic mk_data(input logic [7:0] pidb, input int len);
        logic [15:0] c;
        logic [7:0] b;
        c = 16'hFFFF;
        pkt = '{pidb};
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            pkt.push_back(b);
            c = crc16_byte(c, b);
        end
        c = ~c;
        pkt.push_back(rev8(c[15:8]));
        pkt.push_back(rev8(c[7:0]));
    endtask

    task automatic mk_tok(input logic [7:0] pidb, input logic [10:0] v);
        logic [4:0] c;
        c = ~crc5_bits(5'h1F, {5'h0, v}, 11);
        pkt = '{pidb, v[7:0], {c[0], c[1], c[2], c[3], c[4], v[10:8]}};
    endtask

    task automatic expect_pkt(input int err_at);
        st_t s;
        int n;
        logic [3:0] p;
        logic [15:0] c16;
        s = '0;
        n = pkt.size() - 1;
        if (pkt.size() == 0) s.pe = 1'b1;
        else if (pkt[0][7:4] != ~pkt[0][3:0]) s.pe = 1'b1;
        else begin
            p = pkt[0][3:0];
            pid_q.push_back(p);
            if (err_at > 0) begin
                s.le = 1'b1;
                for (int k = 1; k <= err_at - 4; k++) byte_q.push_back({k == 1, 1'b0, pkt[k]});
                s.cnt = (err_at > 4) ? 11'(err_at - 4) : 11'd0;
            end else if (p[1:0] == 2'b01 || p == 4'h4) begin
                if (n != 2) s.le = 1'b1;
                else begin
                    s.ce   = (crc5_bits(5'h1F, {pkt[2], pkt[1]}, 16) != 5'b01100);
                    s.tok  = 1'b1;
                    s.addr = pkt[1][6:0];
                    s.endp = {pkt[2][2:0], pkt[1][7]};
                    s.frm  = {pkt[2][2:0], pkt[1]};
                end
            end else if (p[1:0] == 2'b11) begin
                if (n < 2) s.le = 1'b1;
                else if (n > MAX + 2) begin
                    s.le = 1'b1;
                    for (int k = 1; k <= MAX - 1; k++) byte_q.push_back({k == 1, 1'b0, pkt[k]});
                    s.cnt = 11'(MAX - 1);
                end else begin
                    for (int k = 1; k <= n - 2; k++) byte_q.push_back({k == 1, k == n - 2, pkt[k]});
                    s.cnt  = 11'(n - 2);
                    s.eopc = (n > 2);
                    c16 = 16'hFFFF;
                    for (int k = 1; k <= n; k++) c16 = crc16_byte(c16, pkt[k]);
                    s.ce = (c16 != 16'h800D);
                end
            end else if (p[1:0] == 2'b10) s.le = (n > 0);
        end
        st_q.push_back(s);
    endtask

    task automatic send(input int gap, input int err_at);
        @(posedge clk); #1; act = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < pkt.size(); i++) begin
            d = pkt[i];
            vld = 1'b1;
            if (err_at >= 0 && i >= err_at) rxe = 1'b1;
            @(posedge clk); #1; vld = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
        end
        act = 1'b0;
        rxe = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
    endtask

    task automatic run(input int gap, input int err_at);
        expect_pkt(err_at);
        send(gap, err_at);
    endtask

    always @(negedge clk) begin
        eop_d <= rx_packet_valid & rx_packet_eop;
        if (rx_pid_valid) begin
            if (pid_q.size() == 0) chk("pid_extra", pid_q.size(), 1);
            else begin chk("pid", rx_pid, pid_q[0]); pid_q.delete(0); end
        end
        if (rx_packet_valid) begin
            if (byte_q.size() == 0) chk("byte_extra", byte_q.size(), 1);
            else begin chk("byte", {rx_packet_sop, rx_packet_eop, rx_packet_data}, byte_q[0]); byte_q.delete(0); end
        end
        if (rx_done) begin
            if (st_q.size() == 0) chk("done_extra", st_q.size(), 1);
            else begin
                chk("pid_err", rx_pid_err, st_q[0].pe);
                chk("crc_err", rx_crc_err, st_q[0].ce);
                chk("len_err", rx_len_err, st_q[0].le);
                chk("count", rx_byte_count, st_q[0].cnt);
                if (st_q[0].eopc) chk("done_after_eop", eop_d, 1);
                if (st_q[0].tok) chk("token", {rx_token_addr, rx_token_endp, rx_frame_num},
                                     {st_q[0].addr, st_q[0].endp, st_q[0].frm});
                st_q.delete(0);
            end
        end
    end

    initial begin
        #(1_000_000);
        $display("FAIL watchdog: simulation did not complete, n_vec %0d", n_vec);
        $fatal(1);
    end

    initial begin
        logic [7:0] rb [4];
        rb = '{8'hC3, 8'h80, 8'h06, 8'h00};
        rst = 1'b1; act = 1'b0; vld = 1'b0; rxe = 1'b0; d = '0;
        repeat (3) @(posedge clk); #1;
        chk("rst_pid", rx_pid, 0);
        chk("rst_strobes", {rx_pid_valid, rx_packet_valid, rx_done}, 0);
        chk("rst_status", {rx_crc_err, rx_pid_err, rx_len_err, rx_byte_count}, 0);
        rst = 1'b0;

        pkt = '{8'hD2}; run(0, -1);
        pkt = '{8'h2D, 8'h00, 8'h10}; run(0, -1);
        pkt = '{8'h2D, 8'h00, 8'h11}; run(1, -1);
        pkt = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94}; run(0, -1);
        pkt[4] = 8'h02; run(1, -1);
        pkt = '{8'h4B, 8'h00, 8'h00}; run(0, -1);
        pkt = '{8'h4B, 8'h00}; run(0, -1);
        pkt = '{8'h33, 8'h12, 8'h34}; run(0, -1);
        pkt = {}; run(0, -1);
        pkt = '{8'hD2, 8'h00}; run(0, -1);
        pkt = '{8'h2D, 8'h00, 8'h10, 8'h00}; run(0, -1);
        pkt = '{8'h3C, 8'h11, 8'h22}; run(0, -1);
        pkt = '{8'h78, 8'h11, 8'h22, 8'h33}; run(0, -1);

        // reset in the middle of a data packet, trailing bytes must be ignored
        pid_q.push_back(4'h3);
        @(posedge clk); #1; act = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin d = rb[i]; vld = 1'b1; @(posedge clk); #1; vld = 1'b0; end
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_pid", rx_pid, 0);
        chk("midrst_strobes", {rx_pid_valid, rx_packet_valid, rx_done}, 0);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin d = 8'hA5; vld = 1'b1; @(posedge clk); #1; vld = 1'b0; end
        act = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        pkt = '{8'hD2}; run(0, -1);

        mk_data(8'hC3, 10); run(0, 7);
        mk_data(8'h4B, 2);  run(0, 2);
        for (int t = 0; t < 6; t++) begin
            mk_data(dpids[t % 4], int'($urandom_range(0, 12)));
            run(int'($urandom_range(0, 2)), -1);
        end
        for (int t = 0; t < 4; t++) begin
            mk_tok(tpids[t], 11'($urandom));
            run(int'($urandom_range(0, 1)), -1);
        end
        mk_data(8'hC3, MAX);     run(0, -1);
        mk_data(8'hC3, MAX + 1); run(0, -1);

        repeat (5) begin @(posedge clk); #1; end
        chk("pid_q_left", pid_q.size(), 0);
        chk("byte_q_left", byte_q.size(), 0);
        chk("st_q_left", st_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
